// File: rtl/gf_mulinv_seq_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg
// Shared definitions for the GF(2^N) multiply/inverse block:
//   - gf_state_t : controller states (IDLE, MUL, SQR, ACC, DONE)
//   - MODE_MUL / MODE_INV : encoding of the 'mode' operation select
//   - AES_POLY   : default reduction polynomial x^8+x^4+x^3+x+1 (low 8 bits)
// ---------------------------------------------------------------------------
package gf_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        SQR  = 3'd2,
        ACC  = 3'd3,
        DONE = 3'd4
    } gf_state_t;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_INV = 1'b1;

    localparam logic [7:0] AES_POLY = 8'h1B;

endpackage

// File: rtl/gf_mulinv_seq_if.sv
// ---------------------------------------------------------------------------
// gf_mulinv_seq_if
// Operation/result handshake bundle for gf_mulinv_seq.
//   in_valid/in_ready : operation request handshake (mode, a, b)
//   out_valid/out_ready : result handshake (result)
//   busy : block is working on or holding an operation
// Modports:
//   master : the requester (drives operands, consumes results)
//   slave  : the gf_mulinv_seq block
// ---------------------------------------------------------------------------
interface gf_mulinv_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             busy;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/gf_mul_serial.sv
// ---------------------------------------------------------------------------
// gf_mul_serial
// Bit-serial MSB-first GF(2^WIDTH) multiplier. One multiply takes WIDTH
// clock edges, the first of which is the edge on which 'start' is sampled.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   start    : sample a/b and perform the first step on this edge
//   a, b     : operands (only looked at while start is high)
//   done     : high for the cycle after the last step; p is the product
//   p        : running accumulator / final product
// 'start' may be raised in the same cycle as 'done', so a controller can
// chain multiplies with no idle cycle in between.
// ---------------------------------------------------------------------------
module gf_mul_serial
    import gf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] p
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [CW-1:0]    cnt_q;
    logic             run_q;

    // Multiply by x and reduce: shift left, fold the carried-out bit back in.
    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
        xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    assign done = run_q && (cnt_q == CW'(WIDTH));
    assign p    = acc_q;

    // The start edge already consumes b's MSB against a zero accumulator
    // (xtime(0) is 0), so b is stored pre-shifted and the count starts at 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= {b[WIDTH-2:0], 1'b0};
            acc_q <= b[WIDTH-1] ? a : '0;
            cnt_q <= CW'(1);
            run_q <= 1'b1;
        end else if (run_q && !done) begin
            acc_q <= xtime(acc_q) ^ (b_q[WIDTH-1] ? a_q : '0);
            b_q   <= {b_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
        end else if (done) begin
            run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/gf_mulinv_seq.sv
// ---------------------------------------------------------------------------
// gf_mulinv_seq
// Sequential GF(2^WIDTH) multiplier / inverter built around one shared
// bit-serial multiply core.
//   MUL mode : result = a * b, WIDTH cycles of compute
//   INV mode : result = a^(2^N-2) by square-and-multiply, 2(N-1) multiplies
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : gf_mulinv_seq_if.slave (request/result handshakes, busy)
// All outputs come straight from registers (state, result), so there is no
// combinational path from in_valid or out_ready to any output.
// ---------------------------------------------------------------------------
module gf_mulinv_seq
    import gf_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(AES_POLY)
) (
    input  logic         clk,
    input  logic         rst,
    gf_mulinv_seq_if.slave bus
);

    // Iteration counter only needs to reach WIDTH-2 (last SQR/ACC pair).
    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;

    gf_state_t        state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] bop_q, bop_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IW-1:0]    iter_q, iter_d;
    logic             first_q, first_d;

    logic             core_start;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic             core_done;
    logic [WIDTH-1:0] core_p;

    gf_mul_serial #(
        .WIDTH (WIDTH),
        .POLY  (POLY)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (core_start),
        .a     (core_a),
        .b     (core_b),
        .done  (core_done),
        .p     (core_p)
    );

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            x_q      <= '0;
            r_q      <= '0;
            bop_q    <= '0;
            result_q <= '0;
            iter_q   <= '0;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            r_q      <= r_d;
            bop_q    <= bop_d;
            result_q <= result_d;
            iter_q   <= iter_d;
            first_q  <= first_d;
        end
    end

    // Next-state and core control. The first multiply of an operation is
    // kicked off by first_q in the cycle after the accept; every following
    // multiply is started in the same cycle the previous one reports done,
    // using the fresh product straight off the core, so the chain has no
    // gap cycles and latency depends only on the mode.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        r_d        = r_q;
        bop_d      = bop_q;
        result_d   = result_q;
        iter_d     = iter_q;
        first_d    = 1'b0;
        core_start = 1'b0;
        core_a     = x_q;
        core_b     = x_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    x_d     = bus.a;
                    bop_d   = (bus.mode == MODE_MUL) ? bus.b : '0;
                    r_d     = WIDTH'(1);
                    iter_d  = '0;
                    first_d = 1'b1;
                    state_d = (bus.mode == MODE_INV) ? SQR : MUL;
                end
            end

            MUL: begin
                core_start = first_q;
                core_a     = x_q;
                core_b     = bop_q;
                if (core_done) begin
                    result_d = core_p;
                    state_d  = DONE;
                end
            end

            // x = x*x; on completion immediately launch r*x with the new x.
            SQR: begin
                if (first_q) begin
                    core_start = 1'b1;
                    core_a     = x_q;
                    core_b     = x_q;
                end else if (core_done) begin
                    x_d        = core_p;
                    core_start = 1'b1;
                    core_a     = r_q;
                    core_b     = core_p;
                    state_d    = ACC;
                end
            end

            // r = r*x; either finish or launch the next squaring.
            ACC: begin
                if (core_done) begin
                    r_d = core_p;
                    if (iter_q == IW'(WIDTH - 2)) begin
                        result_d = core_p;
                        state_d  = DONE;
                    end else begin
                        iter_d     = iter_q + IW'(1);
                        core_start = 1'b1;
                        core_a     = x_q;
                        core_b     = x_q;
                        state_d    = SQR;
                    end
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_gf_mulinv_seq.sv
// ---------------------------------------------------------------------------
// tb_gf_mulinv_seq
// Self-checking bench for gf_mulinv_seq. Two instances: WIDTH=8 with the AES
// polynomial and WIDTH=4 with x^4+x+1. Expected results are pushed onto a
// scoreboard queue when an operation is issued and popped when the block
// presents its result. A reference shift-and-reduce multiplier and a
// brute-force inverse search produce expectations for the sweep.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gf_mulinv_seq;
    import gf_pkg::*;

    typedef struct {
        logic [15:0] res;
        int          lat;
        string       tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic use4;

    int   checks = 0;
    int   errors = 0;
    int   meas_lat;
    exp_t sb[$];

    logic [15:0] obs_result;
    logic        obs_valid;
    logic        obs_ready;
    logic        obs_busy;
    logic [15:0] got;

    always #5 clk = ~clk;

    gf_mulinv_seq_if #(.WIDTH(8)) if8 ();
    gf_mulinv_seq_if #(.WIDTH(4)) if4 ();

    gf_mulinv_seq #(.WIDTH(8), .POLY(8'h1B)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    gf_mulinv_seq #(.WIDTH(4), .POLY(4'h3)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    // Route the selected instance's outputs onto common observation signals.
    always_comb begin
        obs_result = use4 ? {12'b0, if4.result} : {8'b0, if8.result};
        obs_valid  = use4 ? if4.out_valid : if8.out_valid;
        obs_ready  = use4 ? if4.in_ready  : if8.in_ready;
        obs_busy   = use4 ? if4.busy      : if8.busy;
    end

    // Reference multiply: carry-less product, then reduce from the top down.
    function automatic logic [15:0] gmul(input logic [15:0] x, input logic [15:0] y,
                                         input int w, input logic [15:0] poly);
        logic [31:0] prod;
        logic [31:0] full;
        prod = '0;
        for (int i = 0; i < w; i++)
            if (y[i]) prod ^= (32'(x) << i);
        full = 32'(poly) | (32'd1 << w);
        for (int i = 2 * w - 2; i >= w; i--)
            if (prod[i]) prod ^= (full << (i - w));
        return prod[15:0];
    endfunction

    function automatic logic [15:0] ginv(input logic [15:0] x, input int w, input logic [15:0] poly);
        if (x == 16'd0) return 16'd0;
        for (int y = 1; y < (1 << w); y++)
            if (gmul(x, 16'(y), w, poly) == 16'd1) return 16'(y);
        return 16'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic driveIn(input logic v, input logic md, input logic [15:0] aa, input logic [15:0] bb);
        if (use4) begin
            if4.in_valid = v;
            if4.mode     = md;
            if4.a        = aa[3:0];
            if4.b        = bb[3:0];
        end else begin
            if8.in_valid = v;
            if8.mode     = md;
            if8.a        = aa[7:0];
            if8.b        = bb[7:0];
        end
    endtask

    task automatic setReady(input logic v);
        if (use4) if4.out_ready = v;
        else      if8.out_ready = v;
    endtask

    // Issue one operation, queue its expectation, and count edges from the
    // accepting edge until out_valid is seen (bounded).
    task automatic applyStimulus(input logic md, input logic [15:0] aa, input logic [15:0] bb,
                                 input logic [15:0] expv, input int explat, input string tag);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (obs_ready !== 1'b1 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, " in_ready before issue"}, 32'(obs_ready), 32'd1);
        e.res = expv;
        e.lat = explat;
        e.tag = tag;
        sb.push_back(e);
        driveIn(1'b1, md, aa, bb);
        @(posedge clk);
        #1;
        driveIn(1'b0, md, aa, bb);
        meas_lat = 0;
        do begin
            @(posedge clk);
            #1;
            meas_lat++;
        end while (obs_valid !== 1'b1 && meas_lat < 1000);
    endtask

    // Pop the oldest expectation, compare, then acknowledge the result.
    task automatic collectResult(output logic [15:0] res);
        exp_t e;
        res = obs_result;
        if (sb.size() == 0) begin
            checkOutput("scoreboard depth", 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        checkOutput({e.tag, " result"}, 32'(obs_result), 32'(e.res));
        checkOutput({e.tag, " latency"}, 32'(meas_lat), 32'(e.lat));
        setReady(1'b1);
        #1;
        checkOutput({e.tag, " in_ready low in DONE"}, 32'(obs_ready), 32'd0);
        @(posedge clk);
        #1;
        setReady(1'b0);
        checkOutput({e.tag, " in_ready after ack"}, 32'(obs_ready), 32'd1);
        checkOutput({e.tag, " out_valid after ack"}, 32'(obs_valid), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        use4 = 1'b0;
        rst  = 1'b1;
        if8.in_valid = 1'b0; if8.mode = 1'b0; if8.a = '0; if8.b = '0; if8.out_ready = 1'b0;
        if4.in_valid = 1'b0; if4.mode = 1'b0; if4.a = '0; if4.b = '0; if4.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset values on both instances.
        for (int k = 0; k < 2; k++) begin
            use4 = (k == 1);
            #1;
            checkOutput("reset in_ready",  32'(obs_ready),  32'd1);
            checkOutput("reset out_valid", 32'(obs_valid),  32'd0);
            checkOutput("reset busy",      32'(obs_busy),   32'd0);
            checkOutput("reset result",    32'(obs_result), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset released");

        // WIDTH=8 directed operations.
        use4 = 1'b0;
        applyStimulus(MODE_MUL, 16'h57, 16'h83, 16'hC1, 9,   "mul 57*83");
        collectResult(got);
        applyStimulus(MODE_INV, 16'h53, 16'hFF, 16'hCA, 113, "inv 53");
        collectResult(got);
        applyStimulus(MODE_INV, 16'h01, 16'h00, 16'h01, 113, "inv 01");
        collectResult(got);
        applyStimulus(MODE_INV, 16'h00, 16'h00, 16'h00, 113, "inv 00");
        collectResult(got);
        applyStimulus(MODE_MUL, 16'hFF, 16'h02, 16'hE5, 9,   "mul ff*02");
        collectResult(got);

        // WIDTH=4, x^4+x+1.
        use4 = 1'b1;
        applyStimulus(MODE_MUL, 16'h2, 16'h9, 16'h1, 5,  "w4 mul 2*9");
        collectResult(got);
        applyStimulus(MODE_INV, 16'h2, 16'h0, 16'h9, 25, "w4 inv 2");
        collectResult(got);
        $display("[TB] directed operations done");

        // Back-pressure: hold DONE for 20 cycles with a stray request.
        use4 = 1'b0;
        applyStimulus(MODE_MUL, 16'h57, 16'h83, 16'hC1, 9, "backpressure mul");
        for (int i = 0; i < 20; i++) begin
            if (i == 10) driveIn(1'b1, MODE_INV, 16'h53, 16'h00);
            if (i == 12) driveIn(1'b0, MODE_INV, 16'h53, 16'h00);
            checkOutput("hold result",    32'(obs_result), 32'hC1);
            checkOutput("hold out_valid", 32'(obs_valid),  32'd1);
            checkOutput("hold in_ready",  32'(obs_ready),  32'd0);
            @(posedge clk);
            #1;
        end
        collectResult(got);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("stray request ignored busy", 32'(obs_busy), 32'd0);
        end

        // Reset in the middle of an inverse.
        @(negedge clk);
        driveIn(1'b1, MODE_INV, 16'h53, 16'h00);
        @(posedge clk);
        #1;
        driveIn(1'b0, MODE_INV, 16'h53, 16'h00);
        repeat (49) @(posedge clk);
        #1;
        checkOutput("busy before abort", 32'(obs_busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort in_ready",  32'(obs_ready),  32'd1);
        checkOutput("abort out_valid", 32'(obs_valid),  32'd0);
        checkOutput("abort busy",      32'(obs_busy),   32'd0);
        checkOutput("abort result",    32'(obs_result), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(MODE_MUL, 16'h02, 16'h87, 16'h15, 9, "post-reset mul 02*87");
        collectResult(got);
        $display("[TB] reset abort done");

        // Sweep: INV(a) against the model, then INV(a)*a must be 1.
        for (int i = 1; i < 256; i++) begin
            applyStimulus(MODE_INV, 16'(i), 16'h00, ginv(16'(i), 8, 16'h1B), 113,
                          $sformatf("sweep inv %02h", i));
            collectResult(got);
            applyStimulus(MODE_MUL, got, 16'(i), 16'h01, 9, $sformatf("sweep mul %02h", i));
            collectResult(got);
        end
        $display("[TB] sweep done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf_mulinv_seq.md
GF_MULINV_SEQ -- requirements
Module: gf_mulinv_seq

Interface
REQ-001 Parameter WIDTH, default 8: field degree N of GF(2^N); legal range 2..16.
REQ-002 Parameter POLY, default 8'h1B: low WIDTH bits of the irreducible reduction polynomial; x^WIDTH term is implicit.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  operands and mode present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 mode  input  1  0 = MUL (a*b), 1 = INV (a^-1); b is ignored when mode is INV.
REQ-008 a, b  input  WIDTH each  field operands, polynomial basis.
REQ-009 out_valid  output  1  result is valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  product or inverse.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, SQR, ACC and DONE, with the state enum defined in gf_pkg.
REQ-014 in_ready SHALL be 1 only in IDLE; an accept occurs on an edge where in_valid and in_ready are both 1; in_valid outside IDLE SHALL be ignored.
REQ-015 Each field multiply SHALL use the bit-serial core, MSB-first: acc <= xtime(acc) ^ (b_bit ? a : 0), where xtime is a left shift followed by XOR with POLY if the shifted-out bit is 1; one multiply takes exactly WIDTH cycles.
REQ-016 MUL mode: accept -> MUL for WIDTH cycles -> DONE; out_valid SHALL rise exactly WIDTH+1 edges after the accepting edge.
REQ-017 INV mode SHALL compute a^(2^N-2) as follows: x=a, r=1; repeat N-1 times {x=x*x (SQR); r=r*x (ACC)}.
REQ-018 INV mode: there are 2(N-1) back-to-back multiplies with no gap cycles; out_valid SHALL rise 2(N-1)*WIDTH+1 edges after the accepting edge (113 for N=8).
REQ-019 Inverse of 0 SHALL be 0, with no special-case path; the latency is unchanged.
REQ-020 DONE: out_valid=1 and result stable until an edge where out_ready=1, then the FSM goes to IDLE; in_ready SHALL become 1 on the following cycle (no same-cycle re-accept).
REQ-021 result SHALL hold its last value in IDLE; only the DONE-state value is significant.
REQ-022 Latency SHALL be independent of operand values.

Reset
REQ-023 While rst is high: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, and all internal registers are 0.
REQ-024 rst asserted mid-operation SHALL abort the operation immediately, with no output produced; the first accept after rst deasserts SHALL behave as a fresh operation.

Structure
REQ-025 Package gf_pkg SHALL hold the FSM state enum, the mode encoding constants MODE_MUL=0 and MODE_INV=1, and the default AES polynomial constant.
REQ-026 The bit-serial multiply step SHALL be one sub-module, gf_mul_serial (parameters WIDTH and POLY; ports start, a, b, done, p), instantiated once and reused for the MUL, SQR and ACC operations.
REQ-027 The design SHALL contain no combinational path from in_valid or out_ready to any output other than through registered state.

Verification
REQ-028 WIDTH=8, mode=0, a=8'h57, b=8'h83 -> result=8'hC1, out_valid exactly 9 edges after accept.
REQ-029 WIDTH=8, mode=1, a=8'h53 -> result=8'hCA after 113 edges; a=8'h01 -> 8'h01; a=8'h00 -> 8'h00.
REQ-030 WIDTH=4, POLY=4'h3, mode=0, a=4'h2, b=4'h9 -> result=4'h1 after 5 edges; mode=1, a=4'h2 -> 4'h9 after 25 edges.
REQ-031 Back-pressure: hold out_ready=0 for 20 cycles in DONE -> result and out_valid stable, in_ready=0, and a new in_valid pulse is not accepted.
REQ-032 Assert rst at cycle 50 of an INV operation -> outputs take reset values immediately; the next MUL 8'h02*8'h87 returns 8'h15.
REQ-033 Exhaustive WIDTH=8 sweep: for every nonzero a, INV(a) MUL a = 8'h01.
